// File: rtl/systolic_skew_buffer.sv
// Lane-dependent delay line feeding or draining the systolic array: skew delays lane i by i*STEP
// enabled cycles, deskew by (PORTS-1-i)*STEP; stall, flush, zero-fill and drain status included.
module systolic_skew_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int PORTS      = 8,
  parameter int STEP       = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             mode,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [PORTS-1:0][DATA_WIDTH-1:0] in,
  output logic [PORTS-1:0][DATA_WIDTH-1:0] out,
  output logic [PORTS-1:0]                 out_valid,
  output logic                             busy,
  output logic                             drain_done
);
  localparam int DEPTH = (PORTS - 1) * STEP;

  logic                             mode_q;
  logic                             mode_eff;
  logic                             adv;
  logic                             accept;
  logic                             busy_nxt;
  logic [PORTS-1:0]                 tap_vld;
  logic [PORTS-1:0][DATA_WIDTH-1:0] tap_dat;

  function automatic int lane_delay(input int lane, input logic m);
    return m ? (PORTS - 1 - lane) * STEP : lane * STEP;
  endfunction

  assign adv      = en & ~flush & ~rst;
  assign accept   = adv & in_valid;
  // Mode only switches while idle so beats already in flight keep their tap.
  assign mode_eff = busy ? mode_q : mode;

  generate
    if (DEPTH > 0) begin : g_store
      // One valid chain serves every lane: all lanes carry the same beat stream.
      logic [DEPTH-1:0]                            vld;
      logic [PORTS-1:0][DEPTH-1:0][DATA_WIDTH-1:0] dat;

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          vld <= '0;
          dat <= '0;
        end else if (en) begin
          vld[0] <= accept;
          for (int k = 1; k < DEPTH; k++) vld[k] <= vld[k-1];
          for (int i = 0; i < PORTS; i++) begin
            dat[i][0] <= in_valid ? in[i] : '0;
            for (int k = 1; k < DEPTH; k++) dat[i][k] <= dat[i][k-1];
          end
        end
      end

      assign busy = |vld;

      always_comb begin
        busy_nxt = accept;
        for (int k = 0; k < DEPTH - 1; k++) busy_nxt = busy_nxt | vld[k];
      end

      always_comb begin
        tap_vld = '0;
        tap_dat = '0;
        for (int i = 0; i < PORTS; i++) begin
          for (int k = 0; k < DEPTH; k++) begin
            if (lane_delay(i, mode_eff) == k + 1) begin
              tap_vld[i] = vld[k];
              tap_dat[i] = dat[i][k];
            end
          end
        end
      end
    end else begin : g_pass
      assign busy     = 1'b0;
      assign busy_nxt = 1'b0;
      assign tap_vld  = '0;
      assign tap_dat  = '0;
    end
  endgenerate

  always_comb begin
    out_valid = '0;
    out       = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (lane_delay(i, mode_eff) == 0) begin
        out_valid[i] = accept;
        if (accept) out[i] = in[i];
      end else begin
        out_valid[i] = tap_vld[i] & adv;
        if (tap_vld[i] & adv) out[i] = tap_dat[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      if (!flush) mode_q <= mode_eff;
      drain_done <= busy & adv & ~busy_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_skew_buffer.sv
// Bench for systolic_skew_buffer: directed table, hand-written corner sequences, and a
// randomized run checked against a beat-age reference model (STEP = 1, 2 and 0 instances).
module tb_systolic_skew_buffer;
  localparam int P = 4;
  localparam int W = 8;
  typedef logic [P-1:0][W-1:0] vec_t;

  logic         clk = 1'b0;
  logic         rst, en, mode, flush, in_valid;
  vec_t         din;
  vec_t         o_a  [3];
  logic [P-1:0] ov_a [3];
  logic         b_a  [3];
  logic         dd_a [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  systolic_skew_buffer #(.DATA_WIDTH(W), .PORTS(P), .STEP(1)) dut_s1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .flush(flush), .in_valid(in_valid), .in(din),
    .out(o_a[0]), .out_valid(ov_a[0]), .busy(b_a[0]), .drain_done(dd_a[0]));
  systolic_skew_buffer #(.DATA_WIDTH(W), .PORTS(P), .STEP(2)) dut_s2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .flush(flush), .in_valid(in_valid), .in(din),
    .out(o_a[1]), .out_valid(ov_a[1]), .busy(b_a[1]), .drain_done(dd_a[1]));
  systolic_skew_buffer #(.DATA_WIDTH(W), .PORTS(P), .STEP(0)) dut_s0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .flush(flush), .in_valid(in_valid), .in(din),
    .out(o_a[2]), .out_valid(ov_a[2]), .busy(b_a[2]), .drain_done(dd_a[2]));

  // Reference model: each accepted beat is kept with the number of enabled edges it has aged.
  typedef struct { bit v; int age; vec_t d; } beat_t;
  beat_t beats [3][8];
  bit    mq    [3];
  bit    mdd   [3];
  int    steps [3] = '{1, 2, 0};

  function automatic int dly(int lane, bit md, int s);
    return md ? (P - 1 - lane) * s : lane * s;
  endfunction

  function automatic bit mbusy(int m);
    for (int k = 0; k < 8; k++) if (beats[m][k].v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s [%0d] t=%0t got=%h exp=%h", nm, idx, $time, got, exp);
    end
  endtask

  task automatic check_models();
    for (int m = 0; m < 3; m++) begin
      bit           adv, meff;
      int           d;
      logic [P-1:0] eov;
      vec_t         eo;
      adv  = en && !flush && !rst;
      meff = mbusy(m) ? mq[m] : mode;
      eov  = '0;
      eo   = '0;
      for (int i = 0; i < P; i++) begin
        d = dly(i, meff, steps[m]);
        if (adv && d == 0 && in_valid) begin
          eov[i] = 1'b1;
          eo[i]  = din[i];
        end else if (adv && d > 0) begin
          for (int k = 0; k < 8; k++)
            if (beats[m][k].v && beats[m][k].age == d) begin
              eov[i] = 1'b1;
              eo[i]  = beats[m][k].d[i];
            end
        end
      end
      chk("model_out_valid", m, 32'(ov_a[m]), 32'(eov));
      chk("model_out", m, o_a[m], eo);
      chk("model_busy", m, 32'(b_a[m]), 32'(mbusy(m)));
      chk("model_drain_done", m, 32'(dd_a[m]), 32'(mdd[m]));
    end
  endtask

  task automatic model_update();
    for (int m = 0; m < 3; m++) begin
      bit wb, meff, placed;
      int dep;
      dep    = (P - 1) * steps[m];
      wb     = mbusy(m);
      meff   = wb ? mq[m] : mode;
      placed = 1'b0;
      if (rst || flush) begin
        for (int k = 0; k < 8; k++) beats[m][k].v = 1'b0;
        if (rst) mq[m] = 1'b0;
        mdd[m] = 1'b0;
      end else begin
        if (en) begin
          for (int k = 0; k < 8; k++)
            if (beats[m][k].v) begin
              beats[m][k].age = beats[m][k].age + 1;
              if (beats[m][k].age > dep) beats[m][k].v = 1'b0;
            end
          if (in_valid && dep > 0)
            for (int k = 0; k < 8; k++)
              if (!placed && !beats[m][k].v) begin
                beats[m][k].v   = 1'b1;
                beats[m][k].age = 1;
                beats[m][k].d   = din;
                placed = 1'b1;
              end
        end
        mdd[m] = wb && en && !mbusy(m);
        mq[m]  = meff;
      end
    end
  endtask

  task automatic drive(bit r, bit e, bit md, bit f, bit iv, vec_t d);
    rst = r; en = e; mode = md; flush = f; in_valid = iv; din = d;
  endtask

  task automatic tick();
    check_models();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, '0);
    @(posedge clk);
    model_update();
    #1;
    tick();
  endtask

  typedef struct {
    bit en, md, iv;
    vec_t din;
    logic [P-1:0] ov;
    vec_t o;
    bit busy, dd;
  } row_t;
  row_t tbl [27];

  function automatic row_t r(bit e, bit md, bit iv, vec_t d, logic [P-1:0] ov, vec_t o, bit b, bit dd);
    row_t x;
    x.en = e; x.md = md; x.iv = iv; x.din = d; x.ov = ov; x.o = o; x.busy = b; x.dd = dd;
    return x;
  endfunction

  initial begin
    bit mr;
    // skew single beat
    tbl[0]  = r(1, 0, 1, 32'h04030201, 4'b0001, 32'h00000001, 0, 0);
    tbl[1]  = r(1, 0, 0, 32'h0,        4'b0010, 32'h00000200, 1, 0);
    tbl[2]  = r(1, 0, 0, 32'h0,        4'b0100, 32'h00030000, 1, 0);
    tbl[3]  = r(1, 0, 0, 32'h0,        4'b1000, 32'h04000000, 1, 0);
    tbl[4]  = r(1, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 1);
    // deskew single beat
    tbl[5]  = r(1, 1, 1, 32'h04030201, 4'b1000, 32'h04000000, 0, 0);
    tbl[6]  = r(1, 1, 0, 32'h0,        4'b0100, 32'h00030000, 1, 0);
    tbl[7]  = r(1, 1, 0, 32'h0,        4'b0010, 32'h00000200, 1, 0);
    tbl[8]  = r(1, 1, 0, 32'h0,        4'b0001, 32'h00000001, 1, 0);
    tbl[9]  = r(1, 1, 0, 32'h0,        4'b0000, 32'h0,        0, 1);
    // stall for two cycles; in_valid during stall must be ignored
    tbl[10] = r(1, 0, 1, 32'h04030201, 4'b0001, 32'h00000001, 0, 0);
    tbl[11] = r(0, 0, 1, 32'hFFFFFFFF, 4'b0000, 32'h0,        1, 0);
    tbl[12] = r(0, 0, 1, 32'hFFFFFFFF, 4'b0000, 32'h0,        1, 0);
    tbl[13] = r(1, 0, 0, 32'h0,        4'b0010, 32'h00000200, 1, 0);
    tbl[14] = r(1, 0, 0, 32'h0,        4'b0100, 32'h00030000, 1, 0);
    tbl[15] = r(1, 0, 0, 32'h0,        4'b1000, 32'h04000000, 1, 0);
    tbl[16] = r(1, 0, 0, 32'h0,        4'b0000, 32'h0,        0, 1);
    // mode flipped while busy, then a deskew beat once idle
    tbl[17] = r(1, 0, 1, 32'h04030201, 4'b0001, 32'h00000001, 0, 0);
    tbl[18] = r(1, 1, 0, 32'h0,        4'b0010, 32'h00000200, 1, 0);
    tbl[19] = r(1, 1, 0, 32'h0,        4'b0100, 32'h00030000, 1, 0);
    tbl[20] = r(1, 1, 0, 32'h0,        4'b1000, 32'h04000000, 1, 0);
    tbl[21] = r(1, 1, 0, 32'h0,        4'b0000, 32'h0,        0, 1);
    tbl[22] = r(1, 1, 1, 32'h04030201, 4'b1000, 32'h04000000, 0, 0);
    tbl[23] = r(1, 1, 0, 32'h0,        4'b0100, 32'h00030000, 1, 0);
    tbl[24] = r(1, 1, 0, 32'h0,        4'b0010, 32'h00000200, 1, 0);
    tbl[25] = r(1, 1, 0, 32'h0,        4'b0001, 32'h00000001, 1, 0);
    tbl[26] = r(1, 1, 0, 32'h0,        4'b0000, 32'h0,        0, 1);

    do_reset();
    drive(0, 1, 0, 0, 0, '0);
    #1;
    for (int m = 0; m < 3; m++) begin
      chk("reset_out_valid", m, 32'(ov_a[m]), 32'h0);
      chk("reset_out", m, o_a[m], 32'h0);
      chk("reset_busy", m, 32'(b_a[m]), 32'h0);
      chk("reset_drain_done", m, 32'(dd_a[m]), 32'h0);
    end
    tick();

    for (int n = 0; n < 27; n++) begin
      drive(0, tbl[n].en, tbl[n].md, 0, tbl[n].iv, tbl[n].din);
      #1;
      chk("tbl_out_valid", n, 32'(ov_a[0]), 32'(tbl[n].ov));
      chk("tbl_out", n, o_a[0], tbl[n].o);
      chk("tbl_busy", n, 32'(b_a[0]), 32'(tbl[n].busy));
      chk("tbl_drain_done", n, 32'(dd_a[0]), 32'(tbl[n].dd));
      tick();
    end

    // flush (pass 0) or rst (pass 1) at cycle 2 of a skew beat
    for (int p = 0; p < 2; p++) begin
      do_reset();
      for (int c = 0; c < 6; c++) begin
        drive(p == 1 && c == 2, 1, 0, p == 0 && c == 2, c == 0, (c == 0) ? vec_t'(32'h04030201) : vec_t'(32'h0));
        #1;
        if (c == 1) chk("clr_lane1", p, o_a[0], 32'h00000200);
        if (c >= 2) chk("clr_out_valid", c, 32'(ov_a[0]), 32'h0);
        if (c >= 3) chk("clr_busy", c, 32'(b_a[0]), 32'h0);
        if (c >= 3) chk("clr_drain_done", c, 32'(dd_a[0]), 32'h0);
        tick();
      end
    end
    drive(0, 1, 0, 0, 1, 32'h0a0b0c0d);
    #1;
    chk("post_rst_ov0", 0, 32'(ov_a[0]), 32'h1);
    tick();
    drive(0, 1, 0, 0, 0, '0);
    #1;
    chk("post_rst_ov1", 1, 32'(ov_a[0]), 32'h2);
    chk("post_rst_out1", 1, o_a[0], 32'h00000c00);
    tick();

    // back-to-back stream through the STEP=2 instance
    do_reset();
    for (int c = 0; c < 12; c++) begin
      logic [P-1:0] eov;
      vec_t         eo;
      vec_t         dv;
      dv = (c < 4) ? vec_t'({4{8'(c + 1)}}) : vec_t'(32'h0);
      drive(0, 1, 0, 0, c < 4, dv);
      #1;
      eov = '0;
      eo  = '0;
      for (int i = 0; i < P; i++)
        if (c >= 2 * i && c <= 2 * i + 3) begin
          eov[i] = 1'b1;
          eo[i]  = 8'(c - 2 * i + 1);
        end
      chk("stream_out_valid", c, 32'(ov_a[1]), 32'(eov));
      chk("stream_out", c, o_a[1], eo);
      chk("stream_busy", c, 32'(b_a[1]), 32'(c >= 1 && c <= 9));
      chk("stream_drain_done", c, 32'(dd_a[1]), 32'(c == 10));
      tick();
    end

    do_reset();
    mr = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      int pct;
      pct = ((n / 50) % 2 == 1) ? 70 : 15;
      if ($urandom_range(0, 9) == 0) mr = ~mr;
      drive($urandom_range(0, 199) < 2, $urandom_range(0, 99) < 80, mr,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < pct, vec_t'($urandom));
      #1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
